// File: rtl/alarm_ring_controller_if.sv
// Alarm-path signal bundle between the time-of-day block and the ring controller.
// The controller sits on the slave side; the time source and buttons drive the master side.
interface alarm_ring_controller_if;
  logic       min_tick;
  logic       sec_tick;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_en;
  logic       stop_btn;
  logic       snooze_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic [1:0] state;

  modport slave (
    input  min_tick,
    input  sec_tick,
    input  cur_hours,
    input  cur_minutes,
    input  alarm_hours,
    input  alarm_minutes,
    input  alarm_en,
    input  stop_btn,
    input  snooze_btn,
    output buzzer,
    output ringing,
    output snoozing,
    output snooze_count,
    output state
  );

  modport master (
    output min_tick,
    output sec_tick,
    output cur_hours,
    output cur_minutes,
    output alarm_hours,
    output alarm_minutes,
    output alarm_en,
    output stop_btn,
    output snooze_btn,
    input  buzzer,
    input  ringing,
    input  snoozing,
    input  snooze_count,
    input  state
  );
endinterface

// File: rtl/alarm_ring_controller.sv
// Alarm ring sequencer: minute-boundary match, buzzer drive,
// stop/snooze handling with bounded snoozes and unattended-ring timeout.
module alarm_ring_controller #(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE       = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  alarm_ring_controller_if.slave bus
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  localparam logic [4:0] SNZ  = 5'(SNOOZE_MIN);
  localparam logic [4:0] TMO  = 5'(RING_TIMEOUT_MIN);
  localparam logic [1:0] MAXS = 2'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic       buz_q, buz_d;
  logic [1:0] sc_q, sc_d;
  logic [4:0] cnt_q, cnt_d;
  logic       ring_q, snz_q;
  logic       stop_q, snzb_q;

  logic stop_e;
  logic snz_e;
  logic match;

  always_comb begin
    stop_e = bus.stop_btn & ~stop_q;
    snz_e  = bus.snooze_btn & ~snzb_q;
    match  = bus.min_tick
           && (bus.alarm_hours < 5'd24)
           && (bus.alarm_minutes < 6'd60)
           && (bus.cur_hours == bus.alarm_hours)
           && (bus.cur_minutes == bus.alarm_minutes);
  end

  always_comb begin
    state_d = state_q;
    buz_d   = buz_q;
    sc_d    = sc_q;
    cnt_d   = cnt_q;
    if (!bus.alarm_en) begin
      state_d = DISARMED;
      buz_d   = 1'b0;
      sc_d    = 2'd0;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d = RINGING;
            buz_d   = 1'b1;
            sc_d    = 2'd0;
            cnt_d   = 5'd0;
          end
        end
        RINGING: begin
          if (stop_e) begin
            state_d = ARMED;
            buz_d   = 1'b0;
            sc_d    = 2'd0;
            cnt_d   = 5'd0;
          end else if (snz_e && (sc_q < MAXS)) begin
            state_d = SNOOZE;
            buz_d   = 1'b0;
            sc_d    = sc_q + 2'd1;
            cnt_d   = SNZ;
          end else begin
            if (bus.sec_tick) buz_d = ~buz_q;
            // timeout wins over a same-cycle buzzer toggle
            if (bus.min_tick) begin
              if (cnt_q + 5'd1 == TMO) begin
                state_d = ARMED;
                buz_d   = 1'b0;
                sc_d    = 2'd0;
                cnt_d   = 5'd0;
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end
          end
        end
        SNOOZE: begin
          if (stop_e) begin
            state_d = ARMED;
            buz_d   = 1'b0;
            sc_d    = 2'd0;
            cnt_d   = 5'd0;
          end else if (bus.min_tick) begin
            if (cnt_q == 5'd1) begin
              state_d = RINGING;
              buz_d   = 1'b1;
              cnt_d   = 5'd0;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      buz_q   <= 1'b0;
      sc_q    <= 2'd0;
      cnt_q   <= 5'd0;
      ring_q  <= 1'b0;
      snz_q   <= 1'b0;
      stop_q  <= 1'b0;
      snzb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buz_q   <= buz_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
      ring_q  <= (state_d == RINGING);
      snz_q   <= (state_d == SNOOZE);
      stop_q  <= bus.stop_btn;
      snzb_q  <= bus.snooze_btn;
    end
  end

  assign bus.buzzer       = buz_q;
  assign bus.ringing      = ring_q;
  assign bus.snoozing     = snz_q;
  assign bus.snooze_count = sc_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller: ring/stop, snooze,
// snooze limit, timeout, priority, async reset and enable timing.
module tb_alarm_ring_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alarm_ring_controller_if bus ();

  alarm_ring_controller #(
    .SNOOZE_MIN(5),
    .RING_TIMEOUT_MIN(10),
    .MAX_SNOOZE(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int h, input int m);
    bus.cur_hours   = 5'(h);
    bus.cur_minutes = 6'(m);
    bus.min_tick    = 1'b1;
    cyc();
    bus.min_tick    = 1'b0;
  endtask

  task automatic sec();
    bus.sec_tick = 1'b1;
    cyc();
    bus.sec_tick = 1'b0;
  endtask

  task automatic snooze();
    bus.snooze_btn = 1'b1;
    cyc();
    bus.snooze_btn = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.min_tick      = 1'b0;
    bus.sec_tick      = 1'b0;
    bus.cur_hours     = 5'd7;
    bus.cur_minutes   = 6'd0;
    bus.alarm_hours   = 5'd7;
    bus.alarm_minutes = 6'd30;
    bus.alarm_en      = 1'b0;
    bus.stop_btn      = 1'b0;
    bus.snooze_btn    = 1'b0;
    #3;
    check("rst_state", 32'(bus.state), 0);
    check("rst_buz", 32'(bus.buzzer), 0);
    check("rst_ring", 32'(bus.ringing), 0);
    check("rst_snz", 32'(bus.snoozing), 0);
    check("rst_cnt", 32'(bus.snooze_count), 0);
    #9 rst_n = 1'b1;
    cyc();

    // ring and stop
    bus.alarm_en = 1'b1;
    cyc();
    check("t1_arm", 32'(bus.state), 1);
    tick(7, 29);
    check("t1_0729", 32'(bus.state), 1);
    tick(7, 30);
    check("t1_ring", 32'(bus.state), 2);
    check("t1_buz", 32'(bus.buzzer), 1);
    check("t1_ringing", 32'(bus.ringing), 1);
    sec();
    check("t1_tog1", 32'(bus.buzzer), 0);
    sec();
    check("t1_tog2", 32'(bus.buzzer), 1);
    sec();
    check("t1_tog3", 32'(bus.buzzer), 0);
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    check("t1_stop", 32'(bus.state), 1);
    check("t1_stopbuz", 32'(bus.buzzer), 0);
    check("t1_stopring", 32'(bus.ringing), 0);
    cyc();

    // snooze cycle
    tick(7, 30);
    check("t2_ring", 32'(bus.state), 2);
    snooze();
    check("t2_snz", 32'(bus.state), 3);
    check("t2_cnt", 32'(bus.snooze_count), 1);
    check("t2_buz", 32'(bus.buzzer), 0);
    check("t2_snzflag", 32'(bus.snoozing), 1);
    for (int i = 1; i <= 4; i++) tick(7, 30 + i);
    check("t2_still", 32'(bus.state), 3);
    tick(7, 35);
    check("t2_rering", 32'(bus.state), 2);
    check("t2_rebuz", 32'(bus.buzzer), 1);

    // snooze limit
    for (int k = 2; k <= 3; k++) begin
      snooze();
      check("t3_snz", 32'(bus.state), 3);
      check("t3_cnt", 32'(bus.snooze_count), 32'(k));
      for (int i = 1; i <= 5; i++) tick(7, 36);
      check("t3_rering", 32'(bus.state), 2);
    end
    snooze();
    check("t3_limit", 32'(bus.state), 2);
    check("t3_limcnt", 32'(bus.snooze_count), 3);
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    check("t3_stop", 32'(bus.state), 1);
    check("t3_clr", 32'(bus.snooze_count), 0);
    cyc();

    // timeout, with a buzzer toggle landing on the timeout tick
    tick(7, 30);
    check("t4_ring", 32'(bus.state), 2);
    for (int i = 1; i <= 9; i++) tick(7, 30 + i);
    check("t4_nine", 32'(bus.state), 2);
    sec();
    check("t4_buz0", 32'(bus.buzzer), 0);
    bus.sec_tick = 1'b1;
    tick(7, 40);
    bus.sec_tick = 1'b0;
    check("t4_tmo", 32'(bus.state), 1);
    check("t4_tmobuz", 32'(bus.buzzer), 0);
    check("t4_tmocnt", 32'(bus.snooze_count), 0);
    tick(8, 0);
    check("t4_0800", 32'(bus.state), 1);

    // priority
    tick(7, 30);
    check("t5_ring", 32'(bus.state), 2);
    bus.stop_btn   = 1'b1;
    bus.snooze_btn = 1'b1;
    cyc();
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
    check("t5_both", 32'(bus.state), 1);
    check("t5_bothcnt", 32'(bus.snooze_count), 0);
    cyc();
    tick(7, 30);
    check("t5_ring2", 32'(bus.state), 2);
    bus.alarm_en = 1'b0;
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    check("t5_dis", 32'(bus.state), 0);
    tick(7, 30);
    check("t5_disnoring", 32'(bus.state), 0);

    // async reset mid-ring
    bus.alarm_en = 1'b1;
    cyc();
    tick(7, 30);
    check("t6_ring", 32'(bus.state), 2);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rststate", 32'(bus.state), 0);
    check("t6_rstbuz", 32'(bus.buzzer), 0);
    check("t6_rstring", 32'(bus.ringing), 0);
    bus.alarm_en = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    check("t6_post", 32'(bus.state), 0);

    // enable raised inside the matching minute
    tick(7, 30);
    bus.alarm_en = 1'b1;
    cyc();
    check("t6_arm", 32'(bus.state), 1);
    cyc();
    check("t6_noring", 32'(bus.state), 1);
    tick(7, 31);
    check("t6_0731", 32'(bus.state), 1);
    tick(12, 0);
    check("t6_1200", 32'(bus.state), 1);
    tick(7, 30);
    check("t6_nextday", 32'(bus.state), 2);
    check("t6_nextbuz", 32'(bus.buzzer), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
- Sequences the alarm path of the alarm-clock design.
- Compares the running time of day against the user-set alarm time (hours and minutes) on each minute boundary.
- Drives the buzzer, and handles stop, snooze with a bounded repeat count, and an automatic ring timeout.
- Sits between the time-of-day counter block and the uo_out pin mux.

Parameters:
SNOOZE_MIN, 5, minutes spent in SNOOZE before re-ringing (1..31)
RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-stop (1..31)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
min_tick  input  1  one-cycle pulse; cur_* already hold the new minute in that cycle
sec_tick  input  1  one-cycle pulse per second
cur_hours  input  5  time-of-day hours, 0..23
cur_minutes  input  6  time-of-day minutes, 0..59
alarm_hours  input  5  alarm hours setting
alarm_minutes  input  6  alarm minutes setting
alarm_en  input  1  level; alarm armed when 1
stop_btn  input  1  synchronized, debounced level
snooze_btn  input  1  synchronized, debounced level
buzzer  output  1  buzzer drive
ringing  output  1  1 while in RINGING
snoozing  output  1  1 while in SNOOZE
snooze_count  output  2  snoozes used in the current alarm event
state  output  2  DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state=DISARMED.
  - buzzer, ringing, snoozing = 0.
  - snooze_count = 0.
  - Internal minute counter = 0.
  - Button history registers = 0.
- All outputs are registered. ringing and snoozing decode the state register.
- Button edges: edge = btn & ~btn_q, with btn_q registered every cycle. A button held through reset produces one edge in the first cycle after reset. That edge is harmless because DISARMED and ARMED ignore buttons.
- Match condition:
  - match = (cur_hours==alarm_hours) && (cur_minutes==alarm_minutes).
  - Evaluated only in cycles where min_tick=1.
  - Out-of-range alarm values never match.
  - Enabling the alarm in the middle of the matching minute does not ring.
- Transition priority, highest first: alarm_en=0, stop edge, snooze edge, min_tick event.
- DISARMED:
  - alarm_en=1 -> ARMED next cycle.
- ARMED:
  - min_tick & match -> RINGING next cycle.
  - On that transition: minute counter = 0, snooze_count = 0.
- RINGING:
  - buzzer = 1 on the first RINGING cycle, then toggles on every sec_tick.
  - stop edge -> ARMED.
  - snooze edge with snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count += 1; minute counter = SNOOZE_MIN.
  - snooze edge with snooze_count==MAX_SNOOZE is ignored; ringing continues.
  - min_tick increments the minute counter. When the counter reaches RING_TIMEOUT_MIN -> ARMED.
- SNOOZE:
  - buzzer = 0.
  - min_tick decrements the minute counter. In the cycle it reaches 0 -> RINGING, with minute counter = 0 and buzzer = 1.
  - snooze edge is ignored.
  - stop edge -> ARMED.
- Any state except DISARMED: alarm_en=0 -> DISARMED next cycle.
- Leaving to ARMED or DISARMED clears snooze_count and the minute counter. buzzer is 0 in every state except RINGING.
- Re-trigger: after returning to ARMED, the same alarm time can only match again 24 h later. An ARMED state entered within the matching minute does not re-ring.
- min_tick and sec_tick in the same cycle: both are processed. A buzzer toggle and a timeout in the same cycle resolve as timeout, so buzzer = 0.
- Asynchronous reset in any state returns to reset values immediately.
- Minute counter width: 5 bits. Counter arithmetic never wraps, because transitions occur at the limit.

Test Plan:
1. Ring and stop: alarm 07:30, alarm_en=1, drive min_tick with cur=07:29 then 07:30.
   - 07:29 -> stays ARMED.
   - 07:30 -> state=2 and buzzer=1 in the next cycle.
   - 3 sec_ticks -> buzzer toggles 1,0,1,0.
   - stop_btn pulse -> state=1, buzzer=0.
2. Snooze cycle: ringing at 07:30, snooze edge -> state=3, snooze_count=1, buzzer=0. Then 5 min_ticks -> state=2 in the cycle after the 5th tick, buzzer=1.
3. Snooze limit: MAX_SNOOZE=3, snooze three times to exhaust snoozes, fourth snooze edge while ringing -> remains state=2, snooze_count=3.
4. Timeout: ringing, 10 min_ticks with no buttons -> state=1, snooze_count=0, buzzer=0. The 08:00 match with a 07:30 alarm does not ring.
5. Priority: stop and snooze rise in the same cycle while ringing -> ARMED. alarm_en dropped in the same cycle as a stop edge -> DISARMED.
6. Reset and enable timing:
   - rst_n low mid-RINGING -> all outputs 0, state=0 without waiting for a clock edge.
   - alarm_en raised in the 07:30 minute after the min_tick -> no ring until the next day's 07:30 min_tick.
